macs_sched: RTL
===============

// Module: macs_sched
// PURPOSE
//  Operand scheduler directly upstream of the 4-lane Macs datapath. Computes one output row
//  R[j] = C[j] +/- sum_k a[k]*B[k][j] (4 lanes per column block j, mod 2^16), as needed for
//  Frodo's B = S*A + E. Fetches operands from SRAMs, drives Macs one k-step at a time,
//  feeds results back as the next C, and writes each finished block out.
// PARAMETERS
//  WIDTH   16  lane width; all arithmetic mod 2^WIDTH
//  K_W     11  width of k_len / a_addr (max 2047 k-steps)
//  NB_W    9   width of nb / c_addr / wr_addr (column blocks of 4 lanes)
//  ADDR_W  19  width of b_addr
// PORTS
//  clk       in   1         clock, rising edge
//  rst       in   1         synchronous, active-high reset
//  start     in   1         1-cycle pulse, accepted only in IDLE
//  k_len     in   K_W       k-steps per block; sampled on accepted start
//  nb        in   NB_W      column blocks; sampled on accepted start
//  op_sub    in   1         0: C + a*B, 1: C - a*B; sampled on accepted start
//  busy      out  1         high from cycle after accepted start until DONE exits
//  done      out  1         1-cycle pulse after the last write
//  a_rd_en   out  1         read a[a_addr]; data valid on a_data next cycle
//  a_addr    out  K_W
//  a_data    in   WIDTH
//  b_rd_en   out  1         read B row-block b_addr = k*nb + j; 1-cycle latency
//  b_addr    out  ADDR_W
//  b_data    in   4*WIDTH   lane i = bits [16i+15:16i]
//  c_rd_en   out  1         read bias block c_addr = j; 1-cycle latency
//  c_addr    out  NB_W
//  c_data    in   4*WIDTH
//  mac_en    out  1         -> Macs en
//  mac_mode  out  1         -> Macs mode; tied 0 (matmul)
//  mac_sig   out  1         -> Macs signal = latched op_sub
//  mac_A     out  WIDTH     -> Macs A
//  mac_B     out  4*WIDTH   -> Macs B_0..B_3
//  mac_C     out  4*WIDTH   -> Macs C_0..C_3
//  mac_valid in   1         <- Macs valid
//  mac_res   in   4*WIDTH   <- Macs result_0..result_3
//  wr_en     out  1         write finished block
//  wr_addr   out  NB_W      = j
//  wr_data   out  4*WIDTH   = accumulator
// BEHAVIOUR
//  Reset: state IDLE; busy, done, all *_rd_en, mac_en, wr_en = 0; addresses, mac_A/B/C,
//   wr_data, acc, k, j, b_base = 0. rst mid-operation aborts immediately, no write, no done.
//  FSM: IDLE -> (start) FETCH_C -> LOAD_C -> ISSUE -> FEED -> WAIT -> ISSUE|WRITE;
//   WRITE -> FETCH_C|DONE; DONE -> IDLE.
//  IDLE: on start latch k_len, nb, op_sub; j=0, b_base=0. If nb==0 go DONE directly.
//  FETCH_C: c_rd_en=1, c_addr=j. LOAD_C: acc<=c_data, k<=0, b_ptr<=j; if k_len==0 -> WRITE.
//  ISSUE: a_rd_en=b_rd_en=1, a_addr=k, b_addr=b_ptr.
//  FEED: mac_en=1 for exactly this cycle; mac_A=a_data, mac_B=b_data, mac_C=acc.
//  WAIT: hold mac_en=0 until mac_valid; then acc<=mac_res, k<=k+1, b_ptr<=b_ptr+nb;
//   if k+1==k_len -> WRITE else ISSUE. mac_valid in any other state is ignored.
//  WRITE: wr_en=1, wr_addr=j, wr_data=acc; j<=j+1; if j+1==nb -> DONE else FETCH_C.
//  DONE: done=1 one cycle, busy=0 next cycle. start while busy is ignored (no restart).
//  b_ptr computed incrementally (no multiplier); sums wrap mod 2^ADDR_W.
//  Macs contract: result lane i = C_i + A*B_i (signal 0) or C_i - A*B_i (signal 1), mod 2^16.
//  Min cycles per k-step = 3 (ISSUE, FEED, WAIT w/ valid); per block overhead = 3.
// TESTING
//  T1 k_len=2 nb=1 op_sub=0 c0={4,0,0,0} a={3,1} B0={2,4,1,5} B1={3,4,1,5}
//     -> one wr_en, wr_addr=0, wr_data lanes {13,16,4,20}; done 1 cycle later.
//  T2 T1 with op_sub=1 -> lanes {0xFFFB,0xFFF0,0xFFFC,0xFFEC}; mac_sig=1 on every mac_en.
//  T3 k_len=2 nb=2 -> b_addr sequence 0,2 (j=0) then 1,3 (j=1); wr_addr 0 then 1.
//  T4 k_len=0 nb=1 c0={7,8,9,10} -> wr_data={7,8,9,10}, mac_en never asserted; nb=0 -> done, no write.
//  T5 a=0xFFFF B lane=2 C lane=1 k_len=1 -> lane 0xFFFF (wrap); delay mac_valid 5 cycles
//     -> FSM holds WAIT, single mac_en per k-step.
//  T6 start during busy -> ignored; rst asserted in WAIT -> next cycle all outputs 0, no wr_en/done.

Source files
------------

// File: rtl/macs_sched.sv
// macs_sched: drives the 4-lane Macs unit one k-step at a time to build R[j] = C[j] +/- sum_k a[k]*B[k][j], block by block.
module macs_sched #(
    parameter int WIDTH  = 16,
    parameter int K_W    = 11,
    parameter int NB_W   = 9,
    parameter int ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [K_W-1:0]       k_len_i,
    input  logic [NB_W-1:0]      nb_i,
    input  logic                 op_sub_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 a_rd_en_o,
    output logic [K_W-1:0]       a_addr_o,
    input  logic [WIDTH-1:0]     a_data_i,
    output logic                 b_rd_en_o,
    output logic [ADDR_W-1:0]    b_addr_o,
    input  logic [4*WIDTH-1:0]   b_data_i,
    output logic                 c_rd_en_o,
    output logic [NB_W-1:0]      c_addr_o,
    input  logic [4*WIDTH-1:0]   c_data_i,
    output logic                 mac_en_o,
    output logic                 mac_mode_o,
    output logic                 mac_sig_o,
    output logic [WIDTH-1:0]     mac_A_o,
    output logic [4*WIDTH-1:0]   mac_B_o,
    output logic [4*WIDTH-1:0]   mac_C_o,
    input  logic                 mac_valid_i,
    input  logic [4*WIDTH-1:0]   mac_res_i,
    output logic                 wr_en_o,
    output logic [NB_W-1:0]      wr_addr_o,
    output logic [4*WIDTH-1:0]   wr_data_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_C, S_LOAD_C, S_ISSUE, S_FEED, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_len_q, k_len_d, k_q, k_d, k_inc;
    logic [NB_W-1:0]     nb_q, nb_d, j_q, j_d, j_inc;
    logic                sub_q, sub_d;
    logic [ADDR_W-1:0]   b_ptr_q, b_ptr_d;
    logic [4*WIDTH-1:0]  acc_q, acc_d;

    assign k_inc      = k_q + K_W'(1);
    assign j_inc      = j_q + NB_W'(1);
    assign busy_o     = state_q != S_IDLE;
    assign mac_mode_o = 1'b0;
    assign mac_sig_o  = sub_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
            nb_q    <= '0;
            sub_q   <= 1'b0;
            k_q     <= '0;
            j_q     <= '0;
            b_ptr_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            nb_q    <= nb_d;
            sub_q   <= sub_d;
            k_q     <= k_d;
            j_q     <= j_d;
            b_ptr_q <= b_ptr_d;
            acc_q   <= acc_d;
        end
    end

    // b_ptr walks k*nb + j by repeated addition of nb, so no multiplier is needed
    always_comb begin
        state_d   = state_q;
        k_len_d   = k_len_q;
        nb_d      = nb_q;
        sub_d     = sub_q;
        k_d       = k_q;
        j_d       = j_q;
        b_ptr_d   = b_ptr_q;
        acc_d     = acc_q;
        done_o    = 1'b0;
        a_rd_en_o = 1'b0;
        a_addr_o  = '0;
        b_rd_en_o = 1'b0;
        b_addr_o  = '0;
        c_rd_en_o = 1'b0;
        c_addr_o  = '0;
        mac_en_o  = 1'b0;
        mac_A_o   = '0;
        mac_B_o   = '0;
        mac_C_o   = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        case (state_q)
            S_IDLE: if (start_i) begin
                k_len_d = k_len_i;
                nb_d    = nb_i;
                sub_d   = op_sub_i;
                j_d     = '0;
                state_d = (nb_i == '0) ? S_DONE : S_FETCH_C;
            end
            S_FETCH_C: begin
                c_rd_en_o = 1'b1;
                c_addr_o  = j_q;
                state_d   = S_LOAD_C;
            end
            S_LOAD_C: begin
                acc_d   = c_data_i;
                k_d     = '0;
                b_ptr_d = ADDR_W'(j_q);
                state_d = (k_len_q == '0) ? S_WRITE : S_ISSUE;
            end
            S_ISSUE: begin
                a_rd_en_o = 1'b1;
                b_rd_en_o = 1'b1;
                a_addr_o  = k_q;
                b_addr_o  = b_ptr_q;
                state_d   = S_FEED;
            end
            S_FEED: begin
                mac_en_o = 1'b1;
                mac_A_o  = a_data_i;
                mac_B_o  = b_data_i;
                mac_C_o  = acc_q;
                state_d  = S_WAIT;
            end
            S_WAIT: if (mac_valid_i) begin
                acc_d   = mac_res_i;
                k_d     = k_inc;
                b_ptr_d = b_ptr_q + ADDR_W'(nb_q);
                state_d = (k_inc == k_len_q) ? S_WRITE : S_ISSUE;
            end
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = j_q;
                wr_data_o = acc_q;
                j_d       = j_inc;
                state_d   = (j_inc == nb_q) ? S_DONE : S_FETCH_C;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
